// File: rtl/ioctl_byte_writer.sv
// ioctl_byte_writer: buffers 16-bit hps_io download words and replays them as
// low-then-high byte writes on a req/ack memory port, with back-pressure and completion.
module ioctl_byte_writer #(
    parameter int DEPTH       = 4,
    parameter int WAIT_MARGIN = 2,
    parameter int ADDR_W      = 25
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [15:0]       ioctl_dout,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_wr,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   byte_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [1:0] IDLE = 2'd0, LO = 2'd1, HI = 2'd2;

    logic [ADDR_W+15:0] fifo_q [DEPTH];
    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]         data_q, data_d, hi_q, hi_d;
    logic               wr_q, wr_d, abort_q, abort_d, pend_q, pend_d, ovf_q, ovf_d;
    logic               dl_q, wait_q, wait_d;
    logic [PW-1:0]      rptr_q, rptr_d, wptr_q, wptr_d, wbase;
    logic [PW:0]        cnt_q, cnt_d;
    logic [ADDR_W:0]    bc_q, bc_d;
    logic               start, fall, full, push, pop, ack, kill;
    logic [ADDR_W+15:0] head;

    assign head = fifo_q[rptr_q];

    always_comb begin
        start   = ioctl_download & ~dl_q;
        fall    = ~ioctl_download & dl_q;
        full    = cnt_q == FULL_CNT;
        push    = ioctl_wr & ioctl_download & (start | ~full);
        ack     = mem_ack & wr_q;
        // an in-flight byte is allowed to finish across a restart, but nothing follows it
        kill    = ack & (abort_q | start);
        pop     = 1'b0;
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        hi_d    = hi_q;
        wr_d    = wr_q;
        if (state_q == IDLE) begin
            pop = (cnt_q != '0) & ~start;
        end else if (ack) begin
            if (kill) begin
                wr_d    = 1'b0;
                state_d = IDLE;
            end else if (state_q == LO) begin
                addr_d  = addr_q + 1'b1;
                data_d  = hi_q;
                state_d = HI;
            end else if (cnt_q != '0) begin
                pop = 1'b1;
            end else begin
                wr_d    = 1'b0;
                state_d = IDLE;
            end
        end
        if (pop) begin
            addr_d  = head[ADDR_W+15:16];
            data_d  = head[7:0];
            hi_d    = head[15:8];
            wr_d    = 1'b1;
            state_d = LO;
        end
        abort_d = wr_q & ~ack & (abort_q | start);
        bc_d    = start ? '0 : (ack & ~kill & ~&bc_q) ? bc_q + 1'b1 : bc_q;
        ovf_d   = ~start & (ovf_q | (ioctl_wr & ioctl_download & full));
        wbase   = start ? '0 : wptr_q;
        rptr_d  = (start ? '0 : rptr_q) + PW'(pop);
        wptr_d  = wbase + PW'(push);
        cnt_d   = (start ? '0 : cnt_q - (PW+1)'(pop)) + (PW+1)'(push);
        wait_d  = int'(cnt_d) >= DEPTH - WAIT_MARGIN;
        pend_d  = ~start & (fall | (pend_q & busy));
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            hi_q    <= '0;
            wr_q    <= 1'b0;
            abort_q <= 1'b0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dl_q    <= 1'b0;
            wait_q  <= 1'b0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            cnt_q   <= '0;
            bc_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            hi_q    <= hi_d;
            wr_q    <= wr_d;
            abort_q <= abort_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            dl_q    <= ioctl_download;
            wait_q  <= wait_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
            bc_q    <= bc_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) fifo_q[wbase] <= {ioctl_addr, ioctl_dout};
    end

    assign ioctl_wait = wait_q;
    assign mem_addr   = addr_q;
    assign mem_data   = data_q;
    assign mem_wr     = wr_q;
    assign busy       = (cnt_q != '0) | wr_q;
    assign done       = pend_q & ~busy;
    assign overflow   = ovf_q;
    assign byte_count = bc_q;
endmodule

// File: tb/tb_ioctl_byte_writer.sv
// tb_ioctl_byte_writer: table-driven single-word vectors plus hand-written burst,
// overflow, restart and reset sequences, with a byte scoreboard on the memory port.
module tb_ioctl_byte_writer;
    localparam int AW = 25;

    logic          clk_sys = 1'b0;
    logic          reset = 1'b1;
    logic          ioctl_download = 1'b0;
    logic          ioctl_wr = 1'b0;
    logic [AW-1:0] ioctl_addr = '0;
    logic [15:0]   ioctl_dout = '0;
    logic          ioctl_wait;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          mem_wr;
    logic          mem_ack = 1'b0;
    logic          busy, done, overflow;
    logic [AW:0]   byte_count;

    ioctl_byte_writer #(.DEPTH(4), .WAIT_MARGIN(2), .ADDR_W(AW)) dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_wr(mem_wr), .mem_ack(mem_ack), .busy(busy), .done(done),
        .overflow(overflow), .byte_count(byte_count)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct { logic [AW-1:0] a; logic [7:0] d; } byte_t;
    typedef struct {
        logic [AW-1:0] a; logic [15:0] d; int dly;
        logic [AW-1:0] la; logic [7:0] ld; logic [AW-1:0] ha; logic [7:0] hd;
    } vec_t;

    byte_t exp_q[$], obs_q[$];
    vec_t  tbl[5];
    int    n_chk = 0, n_fail = 0;
    int    ack_dly = 1, done_cnt = 0, wr_cycles = 0;
    bit    ack_en = 1'b1, collect = 1'b0;

    task automatic chk(string name, logic [63:0] got, logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic expect_b(logic [AW-1:0] a, logic [7:0] d);
        byte_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic put(logic [AW-1:0] a, logic [15:0] d);
        ioctl_wr = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        cyc(1);
        ioctl_wr = 1'b0;
    endtask

    task automatic start_dl();
        ioctl_download = 1'b1;
        cyc(1);
    endtask

    task automatic end_dl_wait(string name);
        int d0, t;
        d0 = done_cnt;
        t = 0;
        ioctl_download = 1'b0;
        while (done_cnt == d0 && t < 300) begin
            cyc(1);
            t++;
        end
        cyc(5);
        chk({name, "_done_once"}, done_cnt - d0, 1);
    endtask

    function automatic logic [15:0] ovf_word(int k);
        return 16'(32'hC300 + k * 17);
    endfunction

    // memory responder: acks ack_dly negedges after a request is seen, checks each accepted byte
    initial begin : resp
        int cnt;
        byte_t e, o;
        cnt = 0;
        forever begin
            @(negedge clk_sys);
            if (mem_ack) mem_ack = 1'b0;
            else if (mem_wr && ack_en) begin
                cnt++;
                if (cnt >= ack_dly) begin
                    cnt = 0;
                    mem_ack = 1'b1;
                    if (collect) begin
                        o.a = mem_addr;
                        o.d = mem_data;
                        obs_q.push_back(o);
                    end else if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL sb_extra: unexpected write addr %0h data %0h", mem_addr, mem_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_addr", mem_addr, e.a);
                        chk("sb_data", mem_data, e.d);
                    end
                end
            end else cnt = 0;
        end
    end

    always @(negedge clk_sys) begin
        if (done) done_cnt++;
        if (mem_wr) wr_cycles++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, k, prev, t, d0, w0;
        bit saw_wait;
        tbl[0] = '{25'h0000100, 16'hBEEF, 1, 25'h0000100, 8'hEF, 25'h0000101, 8'hBE};
        tbl[1] = '{25'h1FFFFFE, 16'h1234, 1, 25'h1FFFFFE, 8'h34, 25'h1FFFFFF, 8'h12};
        tbl[2] = '{25'h0000000, 16'h5A0F, 2, 25'h0000000, 8'h0F, 25'h0000001, 8'h5A};
        tbl[3] = '{25'h0ABCDE,  16'h00FF, 4, 25'h0ABCDE,  8'hFF, 25'h0ABCDF,  8'h00};
        tbl[4] = '{25'h1000000, 16'h8001, 1, 25'h1000000, 8'h01, 25'h1000001, 8'h80};

        cyc(3);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bc", byte_count, 0);
        reset = 1'b0;
        cyc(2);
        chk("idle_done", done, 0);
        chk("idle_ovf", overflow, 0);

        for (int i = 0; i < 5; i++) begin
            ack_dly = tbl[i].dly;
            start_dl();
            expect_b(tbl[i].la, tbl[i].ld);
            expect_b(tbl[i].ha, tbl[i].hd);
            put(tbl[i].a, tbl[i].d);
            end_dl_wait("vec");
            chk("vec_bc", byte_count, 2);
            chk("vec_sb_empty", exp_q.size(), 0);
            chk("vec_ovf", overflow, 0);
            chk("vec_busy", busy, 0);
        end

        ack_dly = 3;
        saw_wait = 1'b0;
        start_dl();
        for (int i = 0; i < 8; i++) begin
            t = 0;
            while (ioctl_wait && t < 200) begin
                saw_wait = 1'b1;
                cyc(1);
                t++;
            end
            expect_b(AW'(2 * i), 8'(8'hA0 + i));
            expect_b(AW'(2 * i + 1), 8'(8'h50 + i));
            put(AW'(2 * i), {8'(8'h50 + i), 8'(8'hA0 + i)});
        end
        end_dl_wait("burst");
        chk("burst_wait_seen", saw_wait, 1);
        chk("burst_ovf", overflow, 0);
        chk("burst_bc", byte_count, 16);
        chk("burst_sb_empty", exp_q.size(), 0);

        collect = 1'b1;
        obs_q.delete();
        start_dl();
        for (int i = 0; i < 8; i++) put(AW'(2 * i), ovf_word(i));
        end_dl_wait("ovf");
        collect = 1'b0;
        n = obs_q.size();
        chk("ovf_flag", overflow, 1);
        chk("ovf_even", n % 2, 0);
        chk("ovf_some", n >= 2, 1);
        chk("ovf_dropped", n < 16, 1);
        chk("ovf_bc", byte_count, n);
        prev = -1;
        for (int p = 0; p < n / 2; p++) begin
            k = int'(obs_q[2 * p].a >> 1);
            if (p == 0) chk("ovf_first_word", k, 0);
            chk("ovf_lo_even", obs_q[2 * p].a[0], 0);
            chk("ovf_order", k > prev && k < 8, 1);
            chk("ovf_lo_data", obs_q[2 * p].d, ovf_word(k) & 16'h00FF);
            chk("ovf_hi_addr", obs_q[2 * p + 1].a, obs_q[2 * p].a + 1);
            chk("ovf_hi_data", obs_q[2 * p + 1].d, ovf_word(k) >> 8);
            prev = k;
        end

        ack_dly = 1;
        ack_en = 1'b0;
        start_dl();
        expect_b(25'h40, 8'h11);
        put(25'h40, 16'h2211);
        t = 0;
        while (!mem_wr && t < 20) begin
            cyc(1);
            t++;
        end
        chk("abort_in_lo", mem_addr, 25'h40);
        put(25'h42, 16'h4433);
        put(25'h44, 16'h6655);
        d0 = done_cnt;
        ioctl_download = 1'b0;
        cyc(1);
        ioctl_download = 1'b1;
        cyc(1);
        chk("abort_bc_clr", byte_count, 0);
        ack_en = 1'b1;
        cyc(10);
        chk("abort_mem_wr", mem_wr, 0);
        chk("abort_busy", busy, 0);
        chk("abort_bc", byte_count, 0);
        chk("abort_sb_empty", exp_q.size(), 0);
        chk("abort_no_done", done_cnt - d0, 0);
        expect_b(25'h60, 8'hFE);
        expect_b(25'h61, 8'hCA);
        put(25'h60, 16'hCAFE);
        end_dl_wait("abort_new");
        chk("abort_new_bc", byte_count, 2);

        ack_dly = 3;
        start_dl();
        expect_b(25'h80, 8'h88);
        put(25'h80, 16'h7788);
        t = 0;
        while (!(mem_wr && mem_addr == 25'h81) && t < 50) begin
            cyc(1);
            t++;
        end
        ack_en = 1'b0;
        chk("rst_in_hi", mem_addr, 25'h81);
        reset = 1'b1;
        #1;
        chk("arst_mem_wr", mem_wr, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_mem_data", mem_data, 0);
        chk("arst_wait", ioctl_wait, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_bc", byte_count, 0);
        ioctl_download = 1'b0;
        cyc(1);
        reset = 1'b0;
        ack_en = 1'b1;
        ack_dly = 1;
        w0 = wr_cycles;
        cyc(10);
        chk("post_rst_no_wr", wr_cycles - w0, 0);
        chk("post_rst_sb_empty", exp_q.size(), 0);
        start_dl();
        expect_b(25'h90, 8'h0D);
        expect_b(25'h91, 8'hF0);
        put(25'h90, 16'hF00D);
        end_dl_wait("post_rst");
        chk("post_rst_bc", byte_count, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
